// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the pipeline hazard / stall controller:
//     - mdu_state_t : MULT/DIV busy-timer state encoding (ST_RUN, ST_BUSY)
//     - REG_ZERO    : architectural $zero; never a real dependency
//     - src_match() : does a producer's destination feed a used source of the
//                     instruction sitting in ID?
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A producer writing $zero never creates a hazard, so rd==0 is rejected
    // here rather than at every call site.
    function automatic logic src_match(
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        logic hit_rs;
        logic hit_rt;
        hit_rs = use_rs && (rd == rs);
        hit_rt = use_rt && (rd == rt);
        return (rd != REG_ZERO) && (hit_rs || hit_rt);
    endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// -----------------------------------------------------------------------------
// mdu_busy_timer
//   Tracks an in-flight MULT/MULTU/DIV/DIVU. An op accepted in cycle 0 reports
//   busy=0 in that cycle and busy=1 for the following (latency-1) cycles, so
//   an HI/LO reader immediately behind it stalls exactly long enough.
//
// Parameters
//   MULT_CYCLES  MULT/MULTU latency (>=1)
//   DIV_CYCLES   DIV/DIVU latency (>=1)
//   CNT_W        counter width, holds max(MULT_CYCLES,DIV_CYCLES)-1
//
// Ports
//   clk      in   core clock
//   rst      in   synchronous active-high reset (abandons any op in flight)
//   start    in   instruction in ID is a MULT/DIV
//   is_div   in   qualifies start: 1=DIV, 0=MULT
//   hold     in   pipeline is stalled this cycle; start is not accepted
//   busy     out  MULT/DIV in flight
// -----------------------------------------------------------------------------
module mdu_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    input  logic hold,
    output logic busy
);

    // Counter reload values: the accept cycle itself is the first of the N.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_t       state;
    mdu_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (start && !hold) begin
                    cnt_nxt = is_div ? DIV_LOAD : MULT_LOAD;
                    // A single-cycle unit never leaves RUN.
                    if (cnt_nxt != '0) begin
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // New starts are held off by the top level while BUSY, so
                // start is deliberately ignored here.
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Hazard / stall controller for the 5-stage MIPS core, beside the ID stage
//   and upstream of the ID/EXE register. Catches what forwarding cannot:
//     - load-use       : load in EXE feeding the instruction in ID
//     - branch-on-load : branch in ID whose operand is a load still in MEM
//     - MULT/DIV       : HI/LO reader or new MULT/DIV while the unit is busy
//   A stall freezes PC and IF/ID and injects a bubble into ID/EXE. With no
//   stall, a taken branch squashes the instruction fetched behind it.
//
// Optional feature (macro HAZARD_PERF_EN):
//   stall_cycles     counts every cycle with stall=1
//   mdu_stall_cycles counts every cycle with an MULT/DIV hazard
//   Both clear on rst and wrap at 2^32. Without the macro the ports and
//   counters do not exist.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   Rs_ID, Rt_ID                  source registers of the ID instruction
//   use_rs_ID, use_rt_ID          ID instruction actually reads Rs / Rt
//   branch_ID                     ID instruction resolves in ID (branch/jr)
//   branch_taken_ID               that branch resolved taken
//   mdu_start_ID, mdu_is_div      ID instruction is MULT (0) / DIV (1)
//   hilo_read_ID                  ID instruction is MFHI/MFLO
//   reg_waddr_EXE, reg_write_EXE, mem_read_EXE   EXE producer
//   reg_waddr_MEM, reg_write_MEM, mem_read_MEM   MEM producer
//   pc_en, ifid_en                PC / IF-ID enables
//   ifid_flush, idexe_flush       IF-ID NOP insert / ID-EXE bubble insert
//   mdu_busy                      MULT/DIV in flight
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic        use_rs_ID,
    input  logic        use_rt_ID,
    input  logic        branch_ID,
    input  logic        branch_taken_ID,
    input  logic        mdu_start_ID,
    input  logic        mdu_is_div,
    input  logic        hilo_read_ID,
    input  logic [4:0]  reg_waddr_EXE,
    input  logic        reg_write_EXE,
    input  logic        mem_read_EXE,
    input  logic [4:0]  reg_waddr_MEM,
    input  logic        reg_write_MEM,
    input  logic        mem_read_MEM,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idexe_flush,
`ifdef HAZARD_PERF_EN
    output logic        mdu_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] mdu_stall_cycles
`else
    output logic        mdu_busy
`endif
);

    logic ld_use;
    logic br_ld;
    logic mdu_haz;
    logic stall;
    logic busy_raw;

    // A load in EXE can only be forwarded from MEM/WB, one cycle too late for
    // any consumer in ID.
    assign ld_use = reg_write_EXE && mem_read_EXE &&
                    src_match(reg_waddr_EXE, Rs_ID, Rt_ID, use_rs_ID, use_rt_ID);

    // Branches compare in ID, so a load still in MEM is also too late. This is
    // what turns a load-to-branch dependency into a two-cycle stall.
    assign br_ld  = branch_ID && reg_write_MEM && mem_read_MEM &&
                    src_match(reg_waddr_MEM, Rs_ID, Rt_ID, use_rs_ID, use_rt_ID);

    // HI/LO are not valid until the unit finishes, and the unit takes only one
    // op at a time.
    assign mdu_haz = busy_raw && (hilo_read_ID || mdu_start_ID);

    assign stall = ld_use || br_ld || mdu_haz;

    mdu_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start_ID),
        .is_div (mdu_is_div),
        .hold   (stall),
        .busy   (busy_raw)
    );

    // During reset the front end is frozen and both pipeline registers are
    // flushed. Otherwise a stall beats a taken branch, because a stalled
    // branch has not really resolved yet.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idexe_flush = 1'b1;
        end else begin
            ifid_flush  = branch_taken_ID;
        end
    end

    // The timer state only returns to RUN at the reset edge, so mask busy
    // combinationally for the reset cycle itself.
    assign mdu_busy = busy_raw && !rst;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles     <= '0;
            mdu_stall_cycles <= '0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (mdu_haz) begin
                mdu_stall_cycles <= mdu_stall_cycles + 32'd1;
            end
        end
    end
`else
    // No performance counters in this build; control behaviour is unchanged.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Self-checking bench for hazard_stall_ctrl (default parameters). A small
//   reference model predicts the outputs for each cycle; the prediction is
//   queued when the inputs are applied and compared when the outputs are
//   sampled on the falling edge. Directed scenarios add constant checks.
//   Output vector order: {pc_en, ifid_en, ifid_flush, idexe_flush, mdu_busy}.
//   Define HAZARD_PERF_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    logic       clk;
    logic       rst;
    logic [4:0] Rs_ID, Rt_ID;
    logic       use_rs_ID, use_rt_ID, branch_ID, branch_taken_ID;
    logic       mdu_start_ID, mdu_is_div, hilo_read_ID;
    logic [4:0] reg_waddr_EXE, reg_waddr_MEM;
    logic       reg_write_EXE, mem_read_EXE, reg_write_MEM, mem_read_MEM;
    logic       pc_en, ifid_en, ifid_flush, idexe_flush, mdu_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, mdu_stall_cycles;
    logic [31:0] m_stall_cnt, m_mdu_cnt;
`endif

    int          n_checks;
    int          n_fail;
    int unsigned busy_rem;   // model: busy cycles still to come
    logic [4:0]  sb_q[$];
    logic [4:0]  obs;

    hazard_stall_ctrl #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs_ID           (Rs_ID),
        .Rt_ID           (Rt_ID),
        .use_rs_ID       (use_rs_ID),
        .use_rt_ID       (use_rt_ID),
        .branch_ID       (branch_ID),
        .branch_taken_ID (branch_taken_ID),
        .mdu_start_ID    (mdu_start_ID),
        .mdu_is_div      (mdu_is_div),
        .hilo_read_ID    (hilo_read_ID),
        .reg_waddr_EXE   (reg_waddr_EXE),
        .reg_write_EXE   (reg_write_EXE),
        .mem_read_EXE    (mem_read_EXE),
        .reg_waddr_MEM   (reg_waddr_MEM),
        .reg_write_MEM   (reg_write_MEM),
        .mem_read_MEM    (mem_read_MEM),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idexe_flush     (idexe_flush),
`ifdef HAZARD_PERF_EN
        .mdu_busy        (mdu_busy),
        .stall_cycles    (stall_cycles),
        .mdu_stall_cycles(mdu_stall_cycles)
`else
        .mdu_busy        (mdu_busy)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_dep(input logic [4:0] rd);
        return (rd != 5'd0) && ((use_rs_ID && rd == Rs_ID) || (use_rt_ID && rd == Rt_ID));
    endfunction

    function automatic logic m_mdu_haz();
        return (busy_rem != 0) && (hilo_read_ID || mdu_start_ID);
    endfunction

    function automatic logic m_stall();
        logic lu, bl;
        lu = reg_write_EXE && mem_read_EXE && m_dep(reg_waddr_EXE);
        bl = branch_ID && reg_write_MEM && mem_read_MEM && m_dep(reg_waddr_MEM);
        return lu || bl || m_mdu_haz();
    endfunction

    function automatic logic [4:0] m_out();
        logic b;
        b = (busy_rem != 0);
        if (rst)       return 5'b00110;
        if (m_stall()) return {4'b0001, b};
        return {2'b11, branch_taken_ID, 1'b0, b};
    endfunction

    task automatic m_advance();
        logic st, mh;
        st = m_stall();
        mh = m_mdu_haz();
`ifdef HAZARD_PERF_EN
        if (rst) begin
            m_stall_cnt = 0;
            m_mdu_cnt   = 0;
        end else begin
            m_stall_cnt = m_stall_cnt + {31'd0, st};
            m_mdu_cnt   = m_mdu_cnt + {31'd0, mh};
        end
`else
        if (mh) begin end
`endif
        if (rst)                        busy_rem = 0;
        else if (busy_rem != 0)         busy_rem = busy_rem - 1;
        else if (mdu_start_ID && !st)   busy_rem = (mdu_is_div ? DIV_CYCLES : MULT_CYCLES) - 1;
    endtask

    // One clock: queue prediction, sample on falling edge, compare, then
    // advance across the rising edge. Inputs change only 1 ns after posedge.
    task automatic cycle(input string tag);
        logic [4:0] exp;
        sb_q.push_back(m_out());
        @(negedge clk);
        obs = {pc_en, ifid_en, ifid_flush, idexe_flush, mdu_busy};
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check(tag, {27'd0, obs}, {27'd0, exp});
        end
`ifdef HAZARD_PERF_EN
        check({tag, "_stall_cnt"}, stall_cycles, m_stall_cnt);
        check({tag, "_mdu_cnt"}, mdu_stall_cycles, m_mdu_cnt);
`endif
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs_ID = 0; Rt_ID = 0; use_rs_ID = 0; use_rt_ID = 0;
        branch_ID = 0; branch_taken_ID = 0;
        mdu_start_ID = 0; mdu_is_div = 0; hilo_read_ID = 0;
        reg_waddr_EXE = 0; reg_write_EXE = 0; mem_read_EXE = 0;
        reg_waddr_MEM = 0; reg_write_MEM = 0; mem_read_MEM = 0;
    endtask

    // MULT/DIV then HI/LO reader right behind; returns stall and busy counts.
    task automatic mdu_then_read(input logic div, input string tag, output int stalls, output int busys);
        bit done;
        stalls = 0; busys = 0; done = 0;
        idle_inputs();
        mdu_start_ID = 1; mdu_is_div = div;
        cycle({tag, "_accept"});
        check({tag, "_accept_free"}, {27'd0, obs}, 32'b11000);
        idle_inputs();
        hilo_read_ID = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle({tag, "_wait"});
            if (obs[0]) busys++;
            if (obs[4]) done = 1;
            else stalls++;
        end
        check({tag, "_reader_passed"}, {31'd0, done}, 32'd1);
        idle_inputs();
    endtask

    initial begin
        int st, bz;
        n_checks = 0; n_fail = 0; busy_rem = 0;
`ifdef HAZARD_PERF_EN
        m_stall_cnt = 0; m_mdu_cnt = 0;
`endif
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;

        // Reset outputs
        cycle("rst0");
        check("rst_outputs", {27'd0, obs}, 32'b00110);
        rst = 0;

        // 1. load-use with ALU consumer: exactly one stall cycle
        reg_write_EXE = 1; mem_read_EXE = 1; reg_waddr_EXE = 5'd8;
        Rs_ID = 5'd8; use_rs_ID = 1; use_rt_ID = 1; Rt_ID = 5'd9;
        cycle("t1_stall");
        check("t1_stall_const", {27'd0, obs}, 32'b00010);
        reg_write_EXE = 0; mem_read_EXE = 0; reg_waddr_EXE = 0;
        reg_write_MEM = 1; mem_read_MEM = 1; reg_waddr_MEM = 5'd8;
        cycle("t1_release");
        check("t1_release_const", {27'd0, obs}, 32'b11000);
        idle_inputs();

        // 2. load then branch on Rt: ld_use, then br_ld, then taken flush
        reg_write_EXE = 1; mem_read_EXE = 1; reg_waddr_EXE = 5'd8;
        branch_ID = 1; branch_taken_ID = 1; use_rs_ID = 1; Rs_ID = 5'd3;
        use_rt_ID = 1; Rt_ID = 5'd8;
        cycle("t2_c1");
        check("t2_c1_const", {27'd0, obs}, 32'b00010);
        reg_write_EXE = 0; mem_read_EXE = 0; reg_waddr_EXE = 0;
        reg_write_MEM = 1; mem_read_MEM = 1; reg_waddr_MEM = 5'd8;
        cycle("t2_c2");
        check("t2_c2_const", {27'd0, obs}, 32'b00010);
        reg_write_MEM = 0; mem_read_MEM = 0;
        cycle("t2_c3");
        check("t2_c3_const", {27'd0, obs}, 32'b11100);
        idle_inputs();

        // 3. load to $zero never stalls (EXE and MEM paths)
        reg_write_EXE = 1; mem_read_EXE = 1; reg_waddr_EXE = 5'd0;
        reg_write_MEM = 1; mem_read_MEM = 1; reg_waddr_MEM = 5'd0;
        branch_ID = 1; use_rs_ID = 1; Rs_ID = 5'd0;
        cycle("t3_zero");
        check("t3_zero_const", {27'd0, obs}, 32'b11000);
        idle_inputs();

        // 4. DIV then MFLO: 31 stalls / 31 busy; MULT: 3 / 3
        rst = 1; cycle("t4_rst"); rst = 0;
        mdu_then_read(1'b1, "t4_div", st, bz);
        check("t4_div_stalls", st, 31);
        check("t4_div_busy", bz, 31);
`ifdef HAZARD_PERF_EN
        check("t6_stall_cycles", stall_cycles, 32'd31);
        check("t6_mdu_stall_cycles", mdu_stall_cycles, 32'd31);
`endif
        mdu_then_read(1'b0, "t4_mult", st, bz);
        check("t4_mult_stalls", st, 3);
        check("t4_mult_busy", bz, 3);

        // New MULT/DIV while busy is stalled, not accepted
        mdu_start_ID = 1; mdu_is_div = 0;
        cycle("t4_first");
        cycle("t4_second_stalled");
        check("t4_second_stalled_const", {27'd0, obs}, 32'b00011);
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle("t4_drain");

        // 5. reset in the middle of a DIV (cnt=10)
        mdu_start_ID = 1; mdu_is_div = 1;
        cycle("t5_accept");
        idle_inputs();
        for (int i = 0; i < 21; i++) cycle("t5_busy");
        check("t5_busy_before_rst", {31'd0, obs[0]}, 32'd1);
        rst = 1;
        cycle("t5_rst");
        check("t5_rst_const", {27'd0, obs}, 32'b00110);
        rst = 0; hilo_read_ID = 1;
        cycle("t5_mfhi");
        check("t5_mfhi_const", {27'd0, obs}, 32'b11000);
        idle_inputs();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 39) == 0);
            Rs_ID           = 5'($urandom_range(0, 3));
            Rt_ID           = 5'($urandom_range(0, 3));
            use_rs_ID       = 1'($urandom_range(0, 1));
            use_rt_ID       = 1'($urandom_range(0, 1));
            branch_ID       = 1'($urandom_range(0, 1));
            branch_taken_ID = 1'($urandom_range(0, 1));
            mdu_start_ID    = ($urandom_range(0, 7) == 0);
            mdu_is_div      = ($urandom_range(0, 3) == 0);
            hilo_read_ID    = ($urandom_range(0, 5) == 0);
            reg_waddr_EXE   = 5'($urandom_range(0, 3));
            reg_write_EXE   = 1'($urandom_range(0, 1));
            mem_read_EXE    = 1'($urandom_range(0, 1));
            reg_waddr_MEM   = 5'($urandom_range(0, 3));
            reg_write_MEM   = 1'($urandom_range(0, 1));
            mem_read_MEM    = 1'($urandom_range(0, 1));
            cycle("rand");
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
